// File: rtl/ball_motion_controller.sv
// Pong ball engine: per-frame motion, wall/paddle reflection, goal detection,
// scoring and serve/delay/game-over sequencing.
module ball_motion_controller #(
    parameter int BIT_WIDTH     = 10,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int BALL_RADIUS   = 4,
    parameter int BALL_SPEED    = 2,
    parameter int SERVE_DELAY   = 60,
    parameter int WIN_SCORE     = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_tick,
    input  logic                 serve,
    input  logic [1:0]           touchingPaddle,
    output logic [BIT_WIDTH-1:0] ball_x,
    output logic [BIT_WIDTH-1:0] ball_y,
    output logic [3:0]           score_p1,
    output logic [3:0]           score_p2,
    output logic                 point_scored,
    output logic                 game_over,
    output logic                 ball_active
);
    localparam int SW   = BIT_WIDTH + 1;
    localparam int CW   = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
    localparam int LAST = (SERVE_DELAY > 0) ? SERVE_DELAY - 1 : 0;

    localparam logic signed [SW-1:0]   SPD  = SW'(BALL_SPEED);
    localparam logic signed [SW-1:0]   LO   = SW'(BALL_RADIUS);
    localparam logic signed [SW-1:0]   X_HI = SW'(SCREEN_WIDTH - 1 - BALL_RADIUS);
    localparam logic signed [SW-1:0]   Y_HI = SW'(SCREEN_HEIGHT - 1 - BALL_RADIUS);
    localparam logic [BIT_WIDTH-1:0]   CX   = BIT_WIDTH'(SCREEN_WIDTH / 2);
    localparam logic [BIT_WIDTH-1:0]   CY   = BIT_WIDTH'(SCREEN_HEIGHT / 2);
    localparam logic [CW-1:0]          CLAST = CW'(LAST);
    localparam logic [3:0]             WIN  = 4'(WIN_SCORE);

    typedef enum logic [1:0] {IDLE, SERVE_WAIT, MOVING, GAME_OVER} state_t;

    state_t                state;
    logic                  dx_right;
    logic                  dy_down;
    logic [CW-1:0]         cnt;

    logic                  dx_eff;
    logic signed [SW-1:0]  nx;
    logic signed [SW-1:0]  ny;
    logic                  goal_left;
    logic                  goal_right;
    logic [3:0]            s1_inc;
    logic [3:0]            s2_inc;

    // Paddle contact forces direction (never toggles) so a sticky flag cannot trap the ball.
    always_comb begin
        dx_eff = dx_right;
        if (touchingPaddle == 2'b01)
            dx_eff = 1'b1;
        else if (touchingPaddle == 2'b10)
            dx_eff = 1'b0;
        nx         = $signed({1'b0, ball_x}) + (dx_eff  ? SPD : -SPD);
        ny         = $signed({1'b0, ball_y}) + (dy_down ? SPD : -SPD);
        goal_left  = (nx <= LO);
        goal_right = !goal_left && (nx >= X_HI);
        s1_inc     = (score_p1 == 4'hF) ? score_p1 : score_p1 + 4'd1;
        s2_inc     = (score_p2 == 4'hF) ? score_p2 : score_p2 + 4'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            ball_x       <= CX;
            ball_y       <= CY;
            dx_right     <= 1'b1;
            dy_down      <= 1'b1;
            score_p1     <= 4'd0;
            score_p2     <= 4'd0;
            cnt          <= '0;
            point_scored <= 1'b0;
            game_over    <= 1'b0;
            ball_active  <= 1'b0;
        end else begin
            point_scored <= 1'b0;
            case (state)
                IDLE: begin
                    if (serve) begin
                        state <= SERVE_WAIT;
                        cnt   <= '0;
                    end
                end
                SERVE_WAIT: begin
                    if (frame_tick) begin
                        if (cnt == CLAST) begin
                            state       <= MOVING;
                            ball_active <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                MOVING: begin
                    if (frame_tick) begin
                        if (goal_left || goal_right) begin
                            // Conceding player receives the serve: ball heads toward the scorer.
                            point_scored <= 1'b1;
                            ball_x       <= CX;
                            ball_y       <= CY;
                            ball_active  <= 1'b0;
                            cnt          <= '0;
                            if (goal_left) begin
                                score_p2 <= s2_inc;
                                dx_right <= 1'b1;
                            end else begin
                                score_p1 <= s1_inc;
                                dx_right <= 1'b0;
                            end
                            if ((goal_left && s2_inc == WIN) || (goal_right && s1_inc == WIN)) begin
                                state     <= GAME_OVER;
                                game_over <= 1'b1;
                            end else begin
                                state <= SERVE_WAIT;
                            end
                        end else begin
                            ball_x   <= nx[BIT_WIDTH-1:0];
                            dx_right <= dx_eff;
                            if (ny <= LO) begin
                                ball_y  <= LO[BIT_WIDTH-1:0];
                                dy_down <= 1'b1;
                            end else if (ny >= Y_HI) begin
                                ball_y  <= Y_HI[BIT_WIDTH-1:0];
                                dy_down <= 1'b0;
                            end else begin
                                ball_y <= ny[BIT_WIDTH-1:0];
                            end
                        end
                    end
                end
                GAME_OVER: begin
                    if (serve) begin
                        state     <= SERVE_WAIT;
                        score_p1  <= 4'd0;
                        score_p2  <= 4'd0;
                        dx_right  <= 1'b1;
                        dy_down   <= 1'b1;
                        cnt       <= '0;
                        game_over <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ball_motion_controller.sv
// Bench for ball_motion_controller: directed serve/reset steps plus randomized
// play checked every cycle against an integer playfield model.
module tb_ball_motion_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_tick = 1'b0;
    logic       serve = 1'b0;
    logic [1:0] touchingPaddle = 2'b00;
    logic [9:0] ball_x, ball_y;
    logic [3:0] score_p1, score_p2;
    logic       point_scored, game_over, ball_active;

    int checks = 0;
    int failures = 0;

    // model: st 0=idle 1=waiting for serve delay 2=in play 3=game over
    int mx, my, mdx, mdy, ms1, ms2, mcnt, mst, mps;
    int goals_seen = 0;
    int overs_seen = 0;

    ball_motion_controller dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .serve(serve),
        .touchingPaddle(touchingPaddle), .ball_x(ball_x), .ball_y(ball_y),
        .score_p1(score_p1), .score_p2(score_p2), .point_scored(point_scored),
        .game_over(game_over), .ball_active(ball_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mx = 320; my = 240; mdx = 1; mdy = 1;
        ms1 = 0; ms2 = 0; mcnt = 0; mst = 0; mps = 0;
    endtask

    task automatic model_step(input bit sv, input bit tk, input bit [1:0] tp);
        int nx, ny;
        mps = 0;
        case (mst)
            0: if (sv) begin mst = 1; mcnt = 0; end
            1: if (tk) begin
                   if (mcnt >= 59) mst = 2;
                   else mcnt++;
               end
            2: if (tk) begin
                   if (tp == 2'b01) mdx = 1;
                   if (tp == 2'b10) mdx = -1;
                   nx = mx + 2 * mdx;
                   ny = my + 2 * mdy;
                   if (nx <= 4 || nx >= 635) begin
                       mps = 1;
                       goals_seen++;
                       if (nx <= 4) begin
                           if (ms2 < 15) ms2++;
                           mdx = 1;
                       end else begin
                           if (ms1 < 15) ms1++;
                           mdx = -1;
                       end
                       mx = 320; my = 240; mcnt = 0;
                       if ((nx <= 4 && ms2 == 7) || (nx >= 635 && ms1 == 7)) begin
                           mst = 3;
                           overs_seen++;
                       end else mst = 1;
                   end else begin
                       mx = nx;
                       if (ny <= 4) begin my = 4; mdy = 1; end
                       else if (ny >= 475) begin my = 475; mdy = -1; end
                       else my = ny;
                   end
               end
            3: if (sv) begin
                   ms1 = 0; ms2 = 0; mdx = 1; mdy = 1; mst = 1; mcnt = 0;
               end
            default: ;
        endcase
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".ball_x"}, int'(ball_x), mx);
        chk({ctx, ".ball_y"}, int'(ball_y), my);
        chk({ctx, ".score_p1"}, int'(score_p1), ms1);
        chk({ctx, ".score_p2"}, int'(score_p2), ms2);
        chk({ctx, ".point_scored"}, int'(point_scored), mps);
        chk({ctx, ".game_over"}, int'(game_over), (mst == 3) ? 1 : 0);
        chk({ctx, ".ball_active"}, int'(ball_active), (mst == 2) ? 1 : 0);
    endtask

    // Called at posedge+1: drive, take one edge, update model, compare.
    task automatic cyc(input bit sv, input bit tk, input bit [1:0] tp, input string ctx);
        serve = sv; frame_tick = tk; touchingPaddle = tp;
        @(posedge clk);
        model_step(sv, tk, tp);
        #1;
        check_all(ctx);
    endtask

    initial begin
        int r;
        bit sv, tk;
        bit [1:0] tp;
        bit found;

        model_reset();
        #12;
        check_all("reset_hold");
        rst = 1'b1;
        @(posedge clk); #1;
        check_all("reset_release");

        // serve then 60 ticks; serve pulses while waiting must not matter
        cyc(1'b1, 1'b1, 2'b00, "serve");
        for (int i = 1; i <= 59; i++)
            cyc((i % 7) == 0, 1'b1, 2'b00, "serve_wait");
        chk("active_before_60", int'(ball_active), 0);
        cyc(1'b0, 1'b1, 2'b00, "tick60");
        chk("active_after_60", int'(ball_active), 1);
        cyc(1'b0, 1'b1, 2'b00, "first_move");
        chk("first_move_x", int'(ball_x), 322);
        chk("first_move_y", int'(ball_y), 242);

        // randomized play
        for (int i = 0; i < 30000; i++) begin
            r  = $urandom_range(9);
            tp = (r < 7) ? 2'b00 : 2'(r - 6);
            tk = ($urandom_range(3) != 0);
            sv = ($urandom_range(39) == 0);
            cyc(sv, tk, tp, "rand");
        end
        chk("goals_happened", (goals_seen > 3) ? 1 : 0, 1);

        // drive into play, then reset between edges
        found = 1'b0;
        for (int i = 0; i < 800 && !found; i++) begin
            cyc(mst != 2, 1'b1, 2'b00, "to_moving");
            if (mst == 2 && mx != 320) found = 1'b1;
        end
        chk("reached_moving", int'(found), 1);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(posedge clk); #1;
        rst = 1'b1;
        cyc(1'b0, 1'b1, 2'b00, "post_reset_idle");
        cyc(1'b0, 1'b1, 2'b00, "post_reset_idle2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
